ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//  Registered ID/EX control stage for the 5-bit-opcode pipelined CPU. Decodes the 32-bit ID instruction
//  into a control bundle, registers it toward EX (1-cycle latency), detects load-use hazards (stall + bubble)
//  and obeys branch/jump flush. Adds jump/branch/link/exception opcodes beyond add/addi/sw/lw.
// PARAMETERS
//  REG_ADDR_W     5   register-specifier width
//  LINK_REG       31  destination written by jal
//  STATUS_REG     30  destination written by setx
//  ENABLE_HAZARD  1   1: load-use interlock active; 0: stall_out tied 0, no bubbles inserted
// PORTS
//  clock        in   1   sole clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  id_instr     in   32  ID instruction: op[31:27] rd[26:22] rs[21:17] rt[16:12] shamt[11:7] aluop[6:2] imm[16:0]
//  id_valid     in   1   id_instr holds a real instruction
//  flush        in   1   EX resolved taken branch/jump; kill instruction in ID
//  stall_out    out  1   hold PC and IF/ID this cycle (combinational)
//  illegal_op   out  1   registered; 1 for one cycle when an undefined instruction was dropped
//  ex_valid     out  1   bundle below is a real instruction
//  ex_alu_op    out  5   final ALU opcode
//  ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd  out 1 each  regfile WE, ALU B=imm, DMEM WE, writeback from DMEM
//  ex_branch    out  2   00 none, 01 bne, 10 blt, 11 bex
//  ex_jump      out  2   00 none, 01 j, 10 jal, 11 jr
//  ex_rd, ex_rs, ex_rt  out REG_ADDR_W each  write dest (after link/status substitution), sources
//  ex_shamt     out  5   shift amount
//  ex_imm       out  27  raw id_instr[26:0] (EX sign-extends [16:0] or uses [26:0] as target)
// BEHAVIOUR
//  - Reset (sync): every registered output 0 (ex_valid=0, illegal_op=0); stall_out then follows its equation.
//  - Decode table (op -> alu_op; rwe inb dmwe rwd):
//    00000 R    -> aluop[6:2]; 1 0 0 0      00101 addi -> 00000; 1 1 0 0
//    00111 sw   -> 00000; 0 1 1 0           01000 lw   -> 00000; 1 1 0 1
//    00010 bne  -> 00001; 0 0 0 0 br=01     00110 blt  -> 00001; 0 0 0 0 br=10
//    00001 j    -> jump=01                  00011 jal  -> rwe=1, rd=LINK_REG, jump=10
//    00100 jr   -> jump=11                  10110 bex  -> br=11
//    10101 setx -> rwe=1, rd=STATUS_REG; unlisted ops: all controls 0, alu_op 00000.
//  - Legal R aluop: 00000..00101 (add,sub,and,or,sll,sra). Other ops or R-aluop -> illegal: ex_valid=0 next
//    cycle, illegal_op=1 for that one cycle.
//  - Writes to $0: rwe forced 0 when final rd==0.
//  - Sources read: R: rs,rt; addi/lw: rs; sw/bne/blt: rd,rs; jr: rd; bex reads STATUS_REG; j/jal/setx none.
//  - Load-use hazard (ENABLE_HAZARD=1): ex_valid & ex_rwd & ex_rd!=0 & id_valid & any source of id_instr ==
//    ex_rd -> stall_out=1; next cycle ex_valid=0 (bubble); ID instruction held upstream, reissued next cycle.
//  - flush=1: next ex_valid=0, illegal_op=0, stall_out forced 0 (flush overrides stall and illegal).
//  - id_valid=0: next ex_valid=0, controls 0, stall_out=0.
//  - Bubble = ex_valid=0 AND ex_rwe=ex_dmwe=ex_rwd=0, ex_branch=ex_jump=0; other fields don't-care.
//  - Latency: decode of id_instr in cycle N visible on ex_* after posedge ending N. No back-to-back stall:
//    after a bubble ex_rwd=0, so the reissued instruction proceeds.
// STRUCTURE
//  - Shared package cpu_isa_pkg: opcode constants (OP_R, OP_ADDI, ...), ALU op constants, branch/jump
//    encodings, instruction field slice localparams, ctrl_bundle_t struct.
//  - Sub-module ctrl_decode_comb: purely combinational instr -> ctrl_bundle_t + src-usage flags + illegal.
//    Top holds hazard compare, flush/stall priority mux and the ID/EX register.
// TESTING
//  1 reset=1 two cycles with id_valid=1 addi -> all ex_* and illegal_op 0; first cycle after release -> ex_valid=0.
//  2 addi $3,$1,5 (op 00101) -> next cycle ex_alu_op=00000, ex_rwe=1, ex_alu_inb=1, ex_rd=3, ex_imm[16:0]=5.
//  3 lw $4,0($2) then add $5,$4,$1 -> stall_out=1 in cycle 2, ex_valid=0 in cycle 3, add issues cycle 4.
//  4 lw $0 then add reading $0, and lw $4 then j -> stall_out=0 both; jal -> ex_rd=31, ex_rwe=1, ex_jump=10.
//  5 bne with flush=1 and simultaneous load-use match -> stall_out=0, next ex_valid=0, ex_branch=00.
//  6 op 11111 and R aluop 01111 -> ex_valid=0 and illegal_op=1 each one cycle; add $0,$1,$2 -> ex_rwe=0.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the pipeline: opcodes, ALU ops, branch/jump codes,
// instruction field positions and the ID/EX control bundle.
package cpu_isa_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_LAST_LEGAL = ALU_SRA;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BLT  = 2'b10;
    localparam logic [1:0] BR_BEX  = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JR   = 2'b11;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_MSB = 11;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;
    localparam int TGT_MSB   = 26;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       rwe;
        logic       alu_inb;
        logic       dmwe;
        logic       rwd;
        logic [1:0] branch;
        logic [1:0] jump;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction decoder: control bundle, final write
// destination, source-register usage for hazard checks, and illegal flag.
module ctrl_decode_comb
    import cpu_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic [31:0]                 instr,
    output ctrl_bundle_t                ctrl,
    output logic [REG_ADDR_W-1:0]       rd_final,
    output logic [REG_ADDR_W-1:0]       rs_field,
    output logic [REG_ADDR_W-1:0]       rt_field,
    output logic [4:0]                  shamt_field,
    output logic [TGT_MSB:0]            imm_field,
    output logic [1:0][REG_ADDR_W-1:0]  src_addr,
    output logic [1:0]                  src_used,
    output logic                        illegal
);

    logic [4:0] op;
    logic [4:0] aluop;
    logic [REG_ADDR_W-1:0] rd_raw;
    logic unused_low_bits;

    assign op          = instr[OP_MSB:OP_LSB];
    assign aluop       = instr[ALUOP_MSB:ALUOP_LSB];
    assign rd_raw      = REG_ADDR_W'(instr[RD_MSB:RD_LSB]);
    assign rs_field    = REG_ADDR_W'(instr[RS_MSB:RS_LSB]);
    assign rt_field    = REG_ADDR_W'(instr[RT_MSB:RT_LSB]);
    assign shamt_field = instr[SHAMT_MSB:SHAMT_LSB];
    assign imm_field   = instr[TGT_MSB:0];
    assign unused_low_bits = ^instr[1:0];

    always_comb begin
        ctrl        = CTRL_NOP;
        rd_final    = rd_raw;
        src_addr[0] = rs_field;
        src_addr[1] = rt_field;
        src_used    = 2'b00;
        illegal     = 1'b0;
        case (op)
            OP_R: begin
                ctrl.alu_op = aluop;
                ctrl.rwe    = 1'b1;
                src_used    = 2'b11;
                illegal     = (aluop > ALU_LAST_LEGAL);
            end
            OP_ADDI: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.rwe     = 1'b1;
                ctrl.alu_inb = 1'b1;
                src_used     = 2'b01;
            end
            OP_SW: begin
                // rd is the store data source, not a destination
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_inb = 1'b1;
                ctrl.dmwe    = 1'b1;
                src_addr[1]  = rd_raw;
                src_used     = 2'b11;
            end
            OP_LW: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.rwe     = 1'b1;
                ctrl.alu_inb = 1'b1;
                ctrl.rwd     = 1'b1;
                src_used     = 2'b01;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = BR_BNE;
                src_addr[1] = rd_raw;
                src_used    = 2'b11;
            end
            OP_BLT: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = BR_BLT;
                src_addr[1] = rd_raw;
                src_used    = 2'b11;
            end
            OP_J: begin
                ctrl.jump = JMP_J;
            end
            OP_JAL: begin
                ctrl.rwe  = 1'b1;
                ctrl.jump = JMP_JAL;
                rd_final  = REG_ADDR_W'(LINK_REG);
            end
            OP_JR: begin
                ctrl.jump   = JMP_JR;
                src_addr[0] = rd_raw;
                src_used    = 2'b01;
            end
            OP_BEX: begin
                ctrl.branch = BR_BEX;
                src_addr[0] = REG_ADDR_W'(STATUS_REG);
                src_used    = 2'b01;
            end
            OP_SETX: begin
                ctrl.rwe = 1'b1;
                rd_final = REG_ADDR_W'(STATUS_REG);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // $0 is hardwired; never let anything claim to write it
        if (rd_final == '0) begin
            ctrl.rwe = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX control stage: decodes the ID instruction, resolves flush/stall/illegal
// priority, detects load-use hazards and registers the bundle toward EX.
module ctrl_decode_pipe
    import cpu_isa_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int LINK_REG      = 31,
    parameter int STATUS_REG    = 30,
    parameter int ENABLE_HAZARD = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            id_instr,
    input  logic                   id_valid,
    input  logic                   flush,
    output logic                   stall_out,
    output logic                   illegal_op,
    output logic                   ex_valid,
    output logic [4:0]             ex_alu_op,
    output logic                   ex_rwe,
    output logic                   ex_alu_inb,
    output logic                   ex_dmwe,
    output logic                   ex_rwd,
    output logic [1:0]             ex_branch,
    output logic [1:0]             ex_jump,
    output logic [REG_ADDR_W-1:0]  ex_rd,
    output logic [REG_ADDR_W-1:0]  ex_rs,
    output logic [REG_ADDR_W-1:0]  ex_rt,
    output logic [4:0]             ex_shamt,
    output logic [26:0]            ex_imm
);

    ctrl_bundle_t                 dec_ctrl;
    logic [REG_ADDR_W-1:0]        dec_rd;
    logic [REG_ADDR_W-1:0]        dec_rs;
    logic [REG_ADDR_W-1:0]        dec_rt;
    logic [4:0]                   dec_shamt;
    logic [26:0]                  dec_imm;
    logic [1:0][REG_ADDR_W-1:0]   dec_src_addr;
    logic [1:0]                   dec_src_used;
    logic                         dec_illegal;

    ctrl_decode_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .LINK_REG   (LINK_REG),
        .STATUS_REG (STATUS_REG)
    ) u_decode (
        .instr       (id_instr),
        .ctrl        (dec_ctrl),
        .rd_final    (dec_rd),
        .rs_field    (dec_rs),
        .rt_field    (dec_rt),
        .shamt_field (dec_shamt),
        .imm_field   (dec_imm),
        .src_addr    (dec_src_addr),
        .src_used    (dec_src_used),
        .illegal     (dec_illegal)
    );

    ctrl_bundle_t          ctrl_reg, ctrl_next;
    logic                  valid_reg, valid_next;
    logic                  illegal_reg, illegal_next;
    logic [REG_ADDR_W-1:0] rd_reg, rs_reg, rt_reg;
    logic [4:0]            shamt_reg;
    logic [26:0]           imm_reg;

    logic [1:0] src_match;
    logic       load_use;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = dec_src_used[gi] && (dec_src_addr[gi] == rd_reg);
        end
    endgenerate

    // A load whose data is not back until after EX cannot feed the next instruction
    assign load_use = valid_reg && ctrl_reg.rwd && (rd_reg != '0) && id_valid && (|src_match);

    generate
        if (ENABLE_HAZARD != 0) begin : g_hazard
            assign stall_out = load_use && !flush;
        end else begin : g_no_hazard
            assign stall_out = 1'b0;
        end
    endgenerate

    always_comb begin
        ctrl_next    = CTRL_NOP;
        valid_next   = 1'b0;
        illegal_next = 1'b0;
        if (flush || !id_valid || stall_out) begin
            ctrl_next = CTRL_NOP;
        end else if (dec_illegal) begin
            illegal_next = 1'b1;
        end else begin
            ctrl_next  = dec_ctrl;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_reg    <= CTRL_NOP;
            valid_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            rd_reg      <= '0;
            rs_reg      <= '0;
            rt_reg      <= '0;
            shamt_reg   <= '0;
            imm_reg     <= '0;
        end else begin
            ctrl_reg    <= ctrl_next;
            valid_reg   <= valid_next;
            illegal_reg <= illegal_next;
            rd_reg      <= dec_rd;
            rs_reg      <= dec_rs;
            rt_reg      <= dec_rt;
            shamt_reg   <= dec_shamt;
            imm_reg     <= dec_imm;
        end
    end

    assign illegal_op = illegal_reg;
    assign ex_valid   = valid_reg;
    assign ex_alu_op  = ctrl_reg.alu_op;
    assign ex_rwe     = ctrl_reg.rwe;
    assign ex_alu_inb = ctrl_reg.alu_inb;
    assign ex_dmwe    = ctrl_reg.dmwe;
    assign ex_rwd     = ctrl_reg.rwd;
    assign ex_branch  = ctrl_reg.branch;
    assign ex_jump    = ctrl_reg.jump;
    assign ex_rd      = rd_reg;
    assign ex_rs      = rs_reg;
    assign ex_rt      = rt_reg;
    assign ex_shamt   = shamt_reg;
    assign ex_imm     = imm_reg;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: reset, decode, load-use interlock,
// flush priority and illegal-instruction handling with hand-computed values.
module tb_ctrl_decode_pipe;
    import cpu_isa_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;
    logic        stall_out, illegal_op, ex_valid;
    logic [4:0]  ex_alu_op;
    logic        ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd;
    logic [1:0]  ex_branch, ex_jump;
    logic [4:0]  ex_rd, ex_rs, ex_rt, ex_shamt;
    logic [26:0] ex_imm;

    int errors = 0;
    int checks = 0;

    ctrl_decode_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .flush      (flush),
        .stall_out  (stall_out),
        .illegal_op (illegal_op),
        .ex_valid   (ex_valid),
        .ex_alu_op  (ex_alu_op),
        .ex_rwe     (ex_rwe),
        .ex_alu_inb (ex_alu_inb),
        .ex_dmwe    (ex_dmwe),
        .ex_rwd     (ex_rwd),
        .ex_branch  (ex_branch),
        .ex_jump    (ex_jump),
        .ex_rd      (ex_rd),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_shamt   (ex_shamt),
        .ex_imm     (ex_imm)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {OP_R, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; id_valid = 1'b1; id_instr = enc_i(OP_ADDI, 5'd3, 5'd1, 17'd5);
        cyc; cyc;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0h want 0", illegal_op); end
        checks++; if ({ex_alu_op, ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd, ex_branch, ex_jump} !== 13'd0) begin
            errors++; $display("FAIL reset_ctrl: got %0h want 0", {ex_alu_op, ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd, ex_branch, ex_jump}); end
        checks++; if ({ex_rd, ex_rs, ex_rt, ex_shamt, ex_imm} !== 47'd0) begin
            errors++; $display("FAIL reset_fields: got %0h want 0", {ex_rd, ex_rs, ex_rt, ex_shamt, ex_imm}); end
        reset = 1'b0; id_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %0h want 0", ex_valid); end
        $display("reset: ex_valid=%0b illegal_op=%0b", ex_valid, illegal_op);
        cyc;
    endtask

    task automatic test_addi;
        id_valid = 1'b1; id_instr = enc_i(OP_ADDI, 5'd3, 5'd1, 17'd5);
        cyc;
        id_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0h want 1", ex_valid); end
        checks++; if ({ex_alu_op, ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd} !== {5'b00000, 4'b1100}) begin
            errors++; $display("FAIL addi_ctrl: got %0h want %0h", {ex_alu_op, ex_rwe, ex_alu_inb, ex_dmwe, ex_rwd}, {5'b00000, 4'b1100}); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL addi_rd: got %0d want 3", ex_rd); end
        checks++; if (ex_rs !== 5'd1) begin errors++; $display("FAIL addi_rs: got %0d want 1", ex_rs); end
        checks++; if (ex_imm[16:0] !== 17'd5) begin errors++; $display("FAIL addi_imm: got %0d want 5", ex_imm[16:0]); end
        $display("addi: ex_rd=%0d ex_imm=%0d ex_rwe=%0b", ex_rd, ex_imm[16:0], ex_rwe);
        cyc;
    endtask

    task automatic test_load_use;
        id_valid = 1'b1; id_instr = enc_i(OP_LW, 5'd4, 5'd2, 17'd0);
        cyc;
        checks++; if ({ex_rwd, ex_rd} !== {1'b1, 5'd4}) begin errors++; $display("FAIL lw_issue: got %0h want %0h", {ex_rwd, ex_rd}, {1'b1, 5'd4}); end
        id_instr = enc_r(5'd5, 5'd4, 5'd1, ALU_ADD);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall_rs: got %0h want 1", stall_out); end
        cyc;
        checks++; if ({ex_valid, ex_rwe, ex_dmwe, ex_rwd, ex_branch, ex_jump} !== 8'd0) begin
            errors++; $display("FAIL lu_bubble: got %0h want 0", {ex_valid, ex_rwe, ex_dmwe, ex_rwd, ex_branch, ex_jump}); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_no_double_stall: got %0h want 0", stall_out); end
        cyc;
        checks++; if ({ex_valid, ex_rwe, ex_rd, ex_rs, ex_rt} !== {2'b11, 5'd5, 5'd4, 5'd1}) begin
            errors++; $display("FAIL lu_reissue: got %0h want %0h", {ex_valid, ex_rwe, ex_rd, ex_rs, ex_rt}, {2'b11, 5'd5, 5'd4, 5'd1}); end
        $display("load_use rs: add reissued ex_rd=%0d", ex_rd);
        id_instr = enc_i(OP_LW, 5'd6, 5'd2, 17'd0);
        cyc;
        id_instr = enc_r(5'd7, 5'd1, 5'd6, ALU_SUB);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall_rt: got %0h want 1", stall_out); end
        $display("load_use rt: stall_out=%0b", stall_out);
        id_valid = 1'b0;
        cyc;
    endtask

    task automatic test_no_stall;
        id_valid = 1'b1; id_instr = enc_i(OP_LW, 5'd0, 5'd2, 17'd0);
        cyc;
        checks++; if ({ex_rwe, ex_rwd} !== 2'b01) begin errors++; $display("FAIL lw0_rwe: got %0h want 1", {ex_rwe, ex_rwd}); end
        id_instr = enc_r(5'd5, 5'd0, 5'd1, ALU_ADD);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lw0_no_stall: got %0h want 0", stall_out); end
        id_instr = enc_i(OP_LW, 5'd4, 5'd2, 17'd0);
        cyc;
        id_instr = {OP_J, 5'd4, 5'd4, 17'd8};
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL j_no_stall: got %0h want 0", stall_out); end
        cyc;
        checks++; if ({ex_valid, ex_jump, ex_rwe} !== {1'b1, JMP_J, 1'b0}) begin
            errors++; $display("FAIL j_decode: got %0h want %0h", {ex_valid, ex_jump, ex_rwe}, {1'b1, JMP_J, 1'b0}); end
        id_instr = {OP_JAL, 27'd100};
        cyc;
        checks++; if ({ex_rd, ex_rwe, ex_jump} !== {5'd31, 1'b1, 2'b10}) begin
            errors++; $display("FAIL jal_decode: got %0h want %0h", {ex_rd, ex_rwe, ex_jump}, {5'd31, 1'b1, 2'b10}); end
        checks++; if (ex_imm !== 27'd100) begin errors++; $display("FAIL jal_target: got %0d want 100", ex_imm); end
        $display("no_stall: jal ex_rd=%0d ex_jump=%0b", ex_rd, ex_jump);
        id_instr = enc_i(OP_LW, 5'd30, 5'd2, 17'd0);
        cyc;
        id_instr = {OP_BEX, 27'd0};
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL bex_status_stall: got %0h want 1", stall_out); end
        $display("bex after lw $30: stall_out=%0b", stall_out);
        id_valid = 1'b0;
        cyc;
    endtask

    task automatic test_flush;
        id_valid = 1'b1; id_instr = enc_i(OP_LW, 5'd4, 5'd2, 17'd0);
        cyc;
        id_instr = enc_i(OP_BNE, 5'd4, 5'd2, 17'd3); flush = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", stall_out); end
        cyc;
        checks++; if ({ex_valid, ex_branch, illegal_op} !== 4'd0) begin
            errors++; $display("FAIL flush_bubble: got %0h want 0", {ex_valid, ex_branch, illegal_op}); end
        flush = 1'b0;
        cyc;
        checks++; if ({ex_valid, ex_branch, ex_alu_op, ex_rwe} !== {1'b1, BR_BNE, ALU_SUB, 1'b0}) begin
            errors++; $display("FAIL bne_decode: got %0h want %0h", {ex_valid, ex_branch, ex_alu_op, ex_rwe}, {1'b1, BR_BNE, ALU_SUB, 1'b0}); end
        id_instr = {5'b11111, 27'd0}; flush = 1'b1;
        cyc;
        checks++; if ({ex_valid, illegal_op} !== 2'b00) begin errors++; $display("FAIL flush_illegal: got %0h want 0", {ex_valid, illegal_op}); end
        $display("flush: ex_valid=%0b illegal_op=%0b", ex_valid, illegal_op);
        flush = 1'b0; id_valid = 1'b0;
        cyc;
    endtask

    task automatic test_illegal;
        id_valid = 1'b1; id_instr = {5'b11111, 27'd0};
        cyc;
        checks++; if ({ex_valid, illegal_op} !== 2'b01) begin errors++; $display("FAIL illegal_op_set: got %0h want 1", {ex_valid, illegal_op}); end
        id_valid = 1'b0;
        cyc;
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_op_pulse: got %0h want 0", illegal_op); end
        id_valid = 1'b1; id_instr = enc_r(5'd1, 5'd2, 5'd3, 5'b01111);
        cyc;
        checks++; if ({ex_valid, illegal_op} !== 2'b01) begin errors++; $display("FAIL illegal_aluop: got %0h want 1", {ex_valid, illegal_op}); end
        id_instr = enc_r(5'd1, 5'd2, 5'd3, ALU_SRA);
        cyc;
        checks++; if ({ex_valid, illegal_op, ex_alu_op} !== {2'b10, ALU_SRA}) begin
            errors++; $display("FAIL sra_legal: got %0h want %0h", {ex_valid, illegal_op, ex_alu_op}, {2'b10, ALU_SRA}); end
        id_instr = enc_r(5'd0, 5'd1, 5'd2, ALU_ADD);
        cyc;
        checks++; if ({ex_valid, ex_rwe} !== 2'b10) begin errors++; $display("FAIL r0_write: got %0h want 2", {ex_valid, ex_rwe}); end
        $display("illegal: add $0 ex_valid=%0b ex_rwe=%0b", ex_valid, ex_rwe);
        id_valid = 1'b0;
        cyc;
        checks++; if ({ex_valid, ex_rwe} !== 2'b00) begin errors++; $display("FAIL idle_bubble: got %0h want 0", {ex_valid, ex_rwe}); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_use;
        test_no_stall;
        test_flush;
        test_illegal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
